// File: rtl/regfile_shadow_if.sv
// Bus between the control unit and the register file: write port, two read
// ports and the Save/Restore handshake.
interface regfile_shadow_if #(
  parameter int W = 8,
  parameter int A = 4
);
  logic         WriteEn;
  logic [A-1:0] Waddr;
  logic [W-1:0] DataIn;
  logic [A-1:0] RaddrA;
  logic [A-1:0] RaddrB;
  logic [W-1:0] DataOutA;
  logic [W-1:0] DataOutB;
  logic         SaveReq;
  logic         RestoreReq;
  logic         Busy;
  logic         Done;
  logic         ShadowValid;

  // Control unit side
  modport master (
    output WriteEn, Waddr, DataIn, RaddrA, RaddrB, SaveReq, RestoreReq,
    input  DataOutA, DataOutB, Busy, Done, ShadowValid
  );

  // Register file side
  modport slave (
    input  WriteEn, Waddr, DataIn, RaddrA, RaddrB, SaveReq, RestoreReq,
    output DataOutA, DataOutB, Busy, Done, ShadowValid
  );
endinterface

// File: rtl/regfile_shadow.sv
// General-purpose register file with two combinational read ports, one
// synchronous write port and a shadow bank for snapshot/rollback sequences.
// A sequence walks one entry per cycle; ordinary writes are dropped while
// a sequence runs, so the control unit must stall on Busy.
module regfile_shadow #(
  parameter int W       = 8,
  parameter int A       = 4,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  regfile_shadow_if.slave   bus
);

  localparam int N = 1 << A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [A-1:0] idx_q, idx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;

  logic [W-1:0] regs_q   [N];
  logic [W-1:0] shadow_q [N];

  logic         wr_ok;
  logic         last_idx;

  // An architectural write lands only when idle and never on a hard-wired R0.
  assign wr_ok    = bus.WriteEn && !busy_q &&
                    !((ZERO_R0 != 0) && (bus.Waddr == '0));
  assign last_idx = (idx_q == {A{1'b1}});

  // Read mux shared by both ports: R0 forced to zero wins over forwarding.
  function automatic logic [W-1:0] read_port(input logic [A-1:0] ra);
    logic [W-1:0] rd;
    rd = regs_q[ra];
    if ((ZERO_R0 != 0) && (ra == '0)) begin
      rd = '0;
    end else if ((BYPASS != 0) && bus.WriteEn && !busy_q && (bus.Waddr == ra)) begin
      rd = bus.DataIn;
    end
    return rd;
  endfunction

  assign bus.DataOutA    = read_port(bus.RaddrA);
  assign bus.DataOutB    = read_port(bus.RaddrB);
  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.ShadowValid = valid_q;

  // Sequence control: pick up a request when idle, walk idx, flag completion.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.SaveReq) begin
          state_d = SAVE;
          idx_d   = '0;
        end else if (bus.RestoreReq && valid_q) begin
          state_d = RESTORE;
          idx_d   = '0;
        end
      end
      SAVE: begin
        idx_d = idx_q + {{(A-1){1'b0}}, 1'b1};
        if (last_idx) begin
          state_d = IDLE;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      RESTORE: begin
        idx_d = idx_q + {{(A-1){1'b0}}, 1'b1};
        if (last_idx) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Sequence state and registered handshake outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // Register array: restore copy or normal write (mutually exclusive, since
  // writes need Busy low and a restore only runs with Busy high).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if ((state_q == RESTORE) && (idx_q == A'(i)) &&
            !((ZERO_R0 != 0) && (i == 0))) begin
          regs_q[i] <= shadow_q[i];
        end else if (wr_ok && (bus.Waddr == A'(i))) begin
          regs_q[i] <= bus.DataIn;
        end
      end
    end
  end

  // Shadow bank: one entry captured per SAVE cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if ((state_q == SAVE) && (idx_q == A'(i))) begin
          shadow_q[i] <= regs_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_shadow.sv
// Directed plus randomized bench for regfile_shadow. A second instance with
// forwarding disabled is driven in lockstep to check the non-bypass read path.
module tb_regfile_shadow;

  localparam int W = 8;
  localparam int A = 4;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_shadow_if #(.W(W), .A(A)) bus ();
  regfile_shadow_if #(.W(W), .A(A)) bus_nb ();

  assign bus_nb.WriteEn    = bus.WriteEn;
  assign bus_nb.Waddr      = bus.Waddr;
  assign bus_nb.DataIn     = bus.DataIn;
  assign bus_nb.RaddrA     = bus.RaddrA;
  assign bus_nb.RaddrB     = bus.RaddrB;
  assign bus_nb.SaveReq    = bus.SaveReq;
  assign bus_nb.RestoreReq = bus.RestoreReq;

  regfile_shadow #(.W(W), .A(A), .ZERO_R0(1), .BYPASS(1)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  regfile_shadow #(.W(W), .A(A), .ZERO_R0(1), .BYPASS(0)) dut_nb (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_nb)
  );

  // Reference model: architectural contents plus remaining sequence length.
  logic [7:0] m_regs [N];
  logic [7:0] m_sh   [N];
  bit         m_valid;
  bit         m_done;
  bit         m_is_restore;
  int         m_left;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [3:0] ra, input bit byp);
    if (ra == 4'd0) return 8'h00;
    if (byp && bus.WriteEn && (m_left == 0) && (bus.Waddr == ra)) return bus.DataIn;
    return m_regs[ra];
  endfunction

  task automatic drive(input bit we, input logic [3:0] wa, input logic [7:0] d,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input bit sv, input bit rs);
    bus.WriteEn    = we;
    bus.Waddr      = wa;
    bus.DataIn     = d;
    bus.RaddrA     = ra;
    bus.RaddrB     = rb;
    bus.SaveReq    = sv;
    bus.RestoreReq = rs;
  endtask

  // Mid-cycle check of every output against the model.
  task automatic half();
    @(negedge clk);
    chk("busy",     32'(bus.Busy),        32'(m_left > 0));
    chk("done",     32'(bus.Done),        32'(m_done));
    chk("svalid",   32'(bus.ShadowValid), 32'(m_valid));
    chk("rdA",      32'(bus.DataOutA),    32'(m_read(bus.RaddrA, 1'b1)));
    chk("rdB",      32'(bus.DataOutB),    32'(m_read(bus.RaddrB, 1'b1)));
    chk("nb_rdA",   32'(bus_nb.DataOutA), 32'(m_read(bus.RaddrA, 1'b0)));
    chk("nb_rdB",   32'(bus_nb.DataOutB), 32'(m_read(bus.RaddrB, 1'b0)));
    chk("nb_busy",  32'(bus_nb.Busy),     32'(m_left > 0));
  endtask

  // Clock edge: advance the model from the inputs applied this cycle.
  task automatic edge_upd();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_regs[i] = 8'h00;
        m_sh[i]   = 8'h00;
      end
      m_valid = 0;
      m_done  = 0;
      m_left  = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        int k;
        k = N - m_left;
        if (m_is_restore && (k != 0)) m_regs[k] = m_sh[k];
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          if (!m_is_restore) m_valid = 1;
        end
      end else begin
        if (bus.WriteEn && (bus.Waddr != 4'd0)) m_regs[bus.Waddr] = bus.DataIn;
        if (bus.SaveReq) begin
          m_sh         = m_regs;
          m_left       = N;
          m_is_restore = 0;
        end else if (bus.RestoreReq && m_valid) begin
          m_left       = N;
          m_is_restore = 1;
        end
      end
    end
    #1;
  endtask

  // Follow a sequence already requested: count Busy cycles until Done, bounded.
  task automatic run_seq(input string name, output int bc, output bit ds);
    bc = 0;
    ds = 0;
    for (int c = 0; c < 40 && !ds; c++) begin
      half();
      if (bus.Busy === 1'b1) bc++;
      if (bus.Done === 1'b1) ds = 1;
      edge_upd();
      bus.WriteEn = 1'b0;
      bus.RaddrA  = 4'($urandom_range(0, 15));
      bus.RaddrB  = 4'($urandom_range(0, 15));
    end
    $display("%s: busy_cycles=%0d done_seen=%0d", name, bc, ds);
  endtask

  initial begin
    int bc;
    bit ds;
    for (int i = 0; i < N; i++) begin
      m_regs[i] = 8'h00;
      m_sh[i]   = 8'h00;
    end
    m_valid = 0; m_done = 0; m_left = 0; m_is_restore = 0;

    // Reset
    rst = 1'b1;
    drive(0, 4'd0, 8'h00, 4'd3, 4'd9, 0, 0);
    edge_upd();
    half();
    chk("reset_busy", 32'(bus.Busy), 32'd0);
    chk("reset_svalid", 32'(bus.ShadowValid), 32'd0);
    chk("reset_rdA", 32'(bus.DataOutA), 32'd0);
    edge_upd();
    rst = 1'b0;
    $display("reset done");

    // Basic write/read and R0 hard-wiring
    drive(1, 4'd3, 8'h5A, 4'd0, 4'd0, 0, 0); half(); edge_upd();
    drive(1, 4'd0, 8'hFF, 4'd0, 4'd0, 0, 0); half(); edge_upd();
    drive(0, 4'd0, 8'h00, 4'd3, 4'd0, 0, 0); half();
    chk("t1_r3", 32'(bus.DataOutA), 32'h5A);
    chk("t1_r0", 32'(bus.DataOutB), 32'h00);
    edge_upd();
    $display("write R3=5A, R0=FF; read R3=%0h R0=%0h", bus.DataOutA, bus.DataOutB);

    // Forwarding vs no forwarding
    drive(1, 4'd5, 8'h33, 4'd5, 4'd5, 0, 0); half();
    chk("fwd_A", 32'(bus.DataOutA), 32'h33);
    chk("fwd_B", 32'(bus.DataOutB), 32'h33);
    chk("nofwd_A", 32'(bus_nb.DataOutA), 32'h00);
    chk("nofwd_B", 32'(bus_nb.DataOutB), 32'h00);
    edge_upd();
    drive(0, 4'd0, 8'h00, 4'd5, 4'd5, 0, 0); half();
    chk("after_fwd_nb", 32'(bus_nb.DataOutA), 32'h33);
    edge_upd();
    $display("forwarding R5=33 checked");

    // Fill Ri = i+0x10 then Save, with a dropped write during Busy
    for (int i = 0; i < N; i++) begin
      drive(1, 4'(i), 8'(i + 16), 4'(i), 4'd0, 0, 0); half(); edge_upd();
    end
    drive(0, 4'd0, 8'h00, 4'd0, 4'd0, 1, 0); half(); edge_upd();
    drive(1, 4'd2, 8'h99, 4'd2, 4'd2, 0, 0);
    run_seq("save", bc, ds);
    chk("save_busy_cycles", 32'(bc), 32'd16);
    chk("save_done", 32'(ds), 32'd1);
    drive(0, 4'd0, 8'h00, 4'd2, 4'd1, 0, 0); half();
    chk("save_r2", 32'(bus.DataOutA), 32'h12);
    chk("save_valid", 32'(bus.ShadowValid), 32'd1);
    edge_upd();

    // Overwrite with 0xEE and Restore
    for (int i = 0; i < N; i++) begin
      drive(1, 4'(i), 8'hEE, 4'(i), 4'd0, 0, 0); half(); edge_upd();
    end
    drive(0, 4'd0, 8'h00, 4'd0, 4'd0, 0, 1); half(); edge_upd();
    run_seq("restore", bc, ds);
    chk("rest_busy_cycles", 32'(bc), 32'd16);
    chk("rest_done", 32'(ds), 32'd1);
    for (int i = 0; i < N; i++) begin
      drive(0, 4'd0, 8'h00, 4'(i), 4'(15 - i), 0, 0); half();
      chk("rest_rd", 32'(bus.DataOutA), (i == 0) ? 32'd0 : 32'(i + 16));
      edge_upd();
    end

    // Both requests together: Save must win
    for (int i = 1; i < N; i++) begin
      drive(1, 4'(i), 8'(i + 64), 4'd0, 4'd0, 0, 0); half(); edge_upd();
    end
    drive(0, 4'd0, 8'h00, 4'd0, 4'd0, 1, 1); half(); edge_upd();
    drive(0, 4'd0, 8'h00, 4'd7, 4'd7, 0, 0);
    run_seq("save+restore", bc, ds);
    chk("both_busy_cycles", 32'(bc), 32'd16);
    drive(0, 4'd0, 8'h00, 4'd7, 4'd1, 0, 0); half();
    chk("both_r7", 32'(bus.DataOutA), 32'h47);
    edge_upd();

    // Reset during the 5th Busy cycle of a Save
    drive(0, 4'd0, 8'h00, 4'd0, 4'd0, 1, 0); half(); edge_upd();
    drive(0, 4'd0, 8'h00, 4'd3, 4'd4, 0, 0);
    for (int c = 0; c < 4; c++) begin
      half(); edge_upd();
    end
    rst = 1'b1;
    half(); edge_upd();
    rst = 1'b0;
    drive(0, 4'd0, 8'h00, 4'd7, 4'd9, 0, 0); half();
    chk("abort_busy", 32'(bus.Busy), 32'd0);
    chk("abort_done", 32'(bus.Done), 32'd0);
    chk("abort_svalid", 32'(bus.ShadowValid), 32'd0);
    chk("abort_rdA", 32'(bus.DataOutA), 32'd0);
    chk("abort_rdB", 32'(bus.DataOutB), 32'd0);
    edge_upd();
    $display("reset mid-save checked");

    // Restore with no valid snapshot is ignored
    drive(1, 4'd7, 8'hA7, 4'd0, 4'd0, 0, 0); half(); edge_upd();
    drive(0, 4'd0, 8'h00, 4'd7, 4'd0, 0, 1); half(); edge_upd();
    drive(0, 4'd0, 8'h00, 4'd7, 4'd0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      half();
      chk("norest_busy", 32'(bus.Busy), 32'd0);
      chk("norest_done", 32'(bus.Done), 32'd0);
      chk("norest_r7", 32'(bus.DataOutA), 32'hA7);
      edge_upd();
    end

    // Fresh Save after the abort
    drive(0, 4'd0, 8'h00, 4'd0, 4'd0, 1, 0); half(); edge_upd();
    drive(0, 4'd0, 8'h00, 4'd0, 4'd0, 0, 0);
    run_seq("save_after_abort", bc, ds);
    chk("resave_busy_cycles", 32'(bc), 32'd16);
    chk("resave_done", 32'(ds), 32'd1);

    // Randomized traffic
    for (int t = 0; t < 600; t++) begin
      drive(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 4));
      rst = ($urandom_range(0, 199) == 0);
      half();
      edge_upd();
    end
    rst = 1'b0;
    $display("random phase done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
